alu_seq: RTL

Parametrised, sequential successor to the combinational UART ALU. Accepts a command (opcode) followed by a stream of operands over a valid/ready handshake. Accumulates the operands (echo, add, multiply), or runs an iterative restoring divide. Presents one result per command on an output valid/ready handshake. Sits between the UART command parser and the UART response formatter.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_divider.sv | 78 +++++++
 rtl/alu_seq.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and helper types for the sequential ALU
//
// Purpose : opcode constants, the controller state enum, the saturating
//           operand-count type and an opcode-recognition helper.
// Ports   : none (package).
package alu_pkg;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_MUL  = 8'hAC;
  localparam logic [7:0] OP_DIV  = 8'hD1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DIVIDE  = 2'd2,
    ST_RESULT  = 2'd3
  } alu_state_e;

  // Operand count; saturates at 3, which only means "more than two".
  typedef logic [1:0] op_count_t;

  function automatic logic op_known(input logic [7:0] op);
    return (op == OP_ECHO) || (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_divider.sv
// rtl/alu_divider.sv - iterative restoring divider, one quotient bit per cycle
//
// Purpose : unsigned restoring division with a fixed WIDTH-iteration latency.
//           The first iteration is performed on the start edge, so done is a
//           one-cycle pulse in the WIDTH-th cycle after start. Divide-by-zero
//           is not handled here; the parent never starts with a zero divisor.
// Ports   : clk, rst (async, active high)
//           start            - load operands and begin
//           dividend,divisor - operands, sampled when start is high
//           done             - one-cycle pulse, quotient/remainder final
//           quotient,remainder
module alu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] rem_q, quo_q, div_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

  logic [WIDTH-1:0] src_rem, src_quo, src_div;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] step_rem, step_quo;

  // One restoring step. The borrow out of the (WIDTH+1)-bit trial subtraction
  // tells whether the divisor fits into the shifted partial remainder.
  always_comb begin
    src_rem = start ? '0       : rem_q;
    src_quo = start ? dividend : quo_q;
    src_div = start ? divisor  : div_q;
    trial    = {src_rem, src_quo[WIDTH-1]} - {1'b0, src_div};
    step_rem = trial[WIDTH] ? {src_rem[WIDTH-2:0], src_quo[WIDTH-1]} : trial[WIDTH-1:0];
    step_quo = {src_quo[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q  <= step_rem;
        quo_q  <= step_quo;
        div_q  <= divisor;
        cnt_q  <= CW'(1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= step_rem;
        quo_q <= step_quo;
        if (cnt_q == CW'(WIDTH - 1)) begin
          busy_q <= 1'b0;
          done   <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: opcode, operand stream, one result per command
//
// Purpose : collects an operand stream for ECHO/ADD/MUL (accumulated on the
//           fly) or DIV (dividend + divisor, then iterative divide) and
//           presents one result with flags on a valid/ready handshake.
// Ports   : clk, rst (async, active high)
//           start_i, opcode_i                     - command start (IDLE only)
//           operand_valid_i/ready_o/_i/last_i     - operand stream
//           result_valid_o, result_ready_i        - result handshake
//           result_o, rem_o, ovf_o, err_o         - result payload and flags
//           busy_o                                - not IDLE
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [7:0]       opcode_i,
  input  logic             operand_valid_i,
  output logic             operand_ready_o,
  input  logic [WIDTH-1:0] operand_i,
  input  logic             operand_last_i,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             ovf_o,
  output logic             err_o,
  output logic             busy_o
);

  import alu_pkg::*;

  alu_state_e       state_q;
  logic [7:0]       opcode_q;
  logic [WIDTH-1:0] acc_q;      // accumulator; holds the dividend for DIV
  op_count_t        cnt_q;
  logic             ovf_q, err_q;

  logic             accept;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] acc_next;
  logic             ovf_next;
  op_count_t        cnt_next;
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  always_comb begin
    accept   = (state_q == ST_COLLECT) && operand_valid_i;
    sum      = {1'b0, acc_q} + {1'b0, operand_i};
    prod     = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, operand_i};
    acc_next = acc_q;
    ovf_next = ovf_q;
    cnt_next = (cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1;
    case (opcode_q)
      OP_ECHO: acc_next = operand_i;
      OP_ADD: begin
        acc_next = sum[WIDTH-1:0];
        ovf_next = ovf_q | sum[WIDTH];
      end
      OP_MUL: begin
        acc_next = prod[WIDTH-1:0];
        ovf_next = ovf_q | (|prod[2*WIDTH-1:WIDTH]);
      end
      OP_DIV: if (cnt_q == 2'd0) acc_next = operand_i;
      default: ;
    endcase
    // The divisor is never stored here: a valid DIV always ends on its second
    // operand, so the divider takes it straight from the operand bus.
    div_start = accept && operand_last_i && (opcode_q == OP_DIV) &&
                (cnt_next == 2'd2) && (operand_i != '0);
  end

  alu_divider #(.WIDTH(WIDTH)) u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (acc_q),
    .divisor   (operand_i),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      opcode_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      result_o <= '0;
      rem_o    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q  <= ST_COLLECT;
            opcode_q <= opcode_i;
            acc_q    <= (opcode_i == OP_MUL) ? WIDTH'(1) : '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (accept) begin
            acc_q <= acc_next;
            ovf_q <= ovf_next;
            cnt_q <= cnt_next;
            if (operand_last_i) begin
              if (opcode_q == OP_DIV) begin
                if (cnt_next != 2'd2) begin
                  result_o <= '0;
                  rem_o    <= '0;
                  err_q    <= 1'b1;
                  state_q  <= ST_RESULT;
                end else if (operand_i == '0) begin
                  result_o <= '1;
                  rem_o    <= acc_q;
                  err_q    <= 1'b1;
                  state_q  <= ST_RESULT;
                end else begin
                  state_q  <= ST_DIVIDE;
                end
              end else begin
                result_o <= op_known(opcode_q) ? acc_next : '0;
                rem_o    <= '0;
                err_q    <= ~op_known(opcode_q);
                state_q  <= ST_RESULT;
              end
            end
          end
        end
        ST_DIVIDE: begin
          if (div_done) begin
            result_o <= div_quo;
            rem_o    <= div_rem;
            state_q  <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          if (result_ready_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign operand_ready_o = (state_q == ST_COLLECT);
  assign result_valid_o  = (state_q == ST_RESULT);
  assign busy_o          = (state_q != ST_IDLE);
  assign ovf_o           = ovf_q;
  assign err_o           = err_q;

endmodule
